// File: rtl/main_ctrl_pkg.sv
// Shared encodings for the multicycle main control FSM: states, opcodes,
// ALU/PC/operand-select codes and the bundled control word.
package main_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11,
    TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIFT = 2'b11;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       regdst;
    logic       alusrca;
    logic [1:0] aluopt;
    logic [1:0] pcsource;
    logic [1:0] alusrcb;
  } ctrl_t;

endpackage

// File: rtl/main_ctrl_decode.sv
// Combinational map from the registered FSM state to datapath controls;
// only the FETCH write enables look at mem_ready.
module main_ctrl_decode
  import main_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   rst_n,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluopt  = ALU_ADD;
        ctrl.pcsource = PC_ALU;
        ctrl.pcwrite = mem_ready;
        ctrl.irwrite = mem_ready;
      end
      DECODE: begin
        ctrl.alusrcb = SRCB_SHIFT;
        ctrl.aluopt  = ALU_ADD;
      end
      MEM_ADDR, ADDI_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluopt  = ALU_ADD;
      end
      MEM_READ: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEM_WRITE: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEM_WB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      R_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REGB;
        ctrl.aluopt  = ALU_FUNCT;
      end
      R_WB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrca     = 1'b1;
        ctrl.alusrcb     = SRCB_REGB;
        ctrl.aluopt      = ALU_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PC_ALUOUT;
      end
      JUMP: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PC_JUMP;
      end
      ADDI_WB: begin
        ctrl.regwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase

    // The reset state is FETCH, which would otherwise drive a memory read
    if (!rst_n) begin
      ctrl.pcwrite     = 1'b0;
      ctrl.pcwritecond = 1'b0;
      ctrl.memread     = 1'b0;
      ctrl.memwrite    = 1'b0;
      ctrl.irwrite     = 1'b0;
      ctrl.regwrite    = 1'b0;
    end
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle main control unit: state register, next-state logic and the
// sticky illegal-opcode flag; output decoding lives in main_ctrl_decode.
module main_control_fsm
  import main_ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] ALUopt,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q;
  logic   illegal_q;
  ctrl_t  ctrl;

  // MEM_ADDR relies on opcode still holding the IR field latched during FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH:     if (mem_ready) state_q <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_q <= MEM_ADDR;
            OP_RTYPE:     state_q <= R_EXEC;
            OP_BEQ:       state_q <= BRANCH;
            OP_J:         state_q <= JUMP;
            OP_ADDI:      state_q <= ADDI_EXEC;
            default: begin
              if (TRAP_ON_ILLEGAL) begin
                state_q   <= TRAP;
                illegal_q <= 1'b1;
              end else begin
                state_q <= FETCH;
              end
            end
          endcase
        end
        MEM_ADDR:  state_q <= (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
        MEM_READ:  if (mem_ready) state_q <= MEM_WB;
        MEM_WRITE: if (mem_ready) state_q <= FETCH;
        MEM_WB:    state_q <= FETCH;
        R_EXEC:    state_q <= R_WB;
        R_WB:      state_q <= FETCH;
        BRANCH:    state_q <= FETCH;
        JUMP:      state_q <= FETCH;
        ADDI_EXEC: state_q <= ADDI_WB;
        ADDI_WB:   state_q <= FETCH;
        TRAP:      state_q <= TRAP;
        default:   state_q <= FETCH;
      endcase
    end
  end

  main_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .rst_n     (rst_n),
    .ctrl      (ctrl)
  );

  assign PCWrite     = ctrl.pcwrite;
  assign PCWriteCond = ctrl.pcwritecond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.memread;
  assign MemWrite    = ctrl.memwrite;
  assign IRWrite     = ctrl.irwrite;
  assign MemtoReg    = ctrl.memtoreg;
  assign RegWrite    = ctrl.regwrite;
  assign RegDst      = ctrl.regdst;
  assign ALUSrcA     = ctrl.alusrca;
  assign ALUopt      = ctrl.aluopt;
  assign PCSource    = ctrl.pcsource;
  assign ALUSrcB     = ctrl.alusrcb;
  assign illegal     = illegal_q;
  assign state       = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: each driven cycle pushes its expected
// state and control word; a negedge monitor pops and compares.
module tb_main_control_fsm;
  import main_ctrl_pkg::*;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctl;
  } item_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;

  logic [1:0] ALUopt, PCSource, ALUSrcB;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegWrite, RegDst, ALUSrcA, illegal;
  logic [3:0] state;

  logic [1:0] ALUopt0, PCSource0, ALUSrcB0;
  logic       PCWrite0, PCWriteCond0, IorD0, MemRead0, MemWrite0, IRWrite0;
  logic       MemtoReg0, RegWrite0, RegDst0, ALUSrcA0, illegal0;
  logic [3:0] state0;

  logic [16:0] obs;
  item_t       sb[$];
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;

  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegWrite, RegDst, ALUSrcA, ALUopt, PCSource,
                ALUSrcB, illegal};

  main_control_fsm #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .ALUopt(ALUopt), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .illegal(illegal), .state(state)
  );

  main_control_fsm #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .ALUopt(ALUopt0), .PCWrite(PCWrite0), .PCWriteCond(PCWriteCond0),
    .IorD(IorD0), .MemRead(MemRead0), .MemWrite(MemWrite0), .IRWrite(IRWrite0),
    .MemtoReg(MemtoReg0), .RegWrite(RegWrite0), .RegDst(RegDst0),
    .ALUSrcA(ALUSrcA0), .PCSource(PCSource0), .ALUSrcB(ALUSrcB0),
    .illegal(illegal0), .state(state0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference control word built straight from the per-state output table
  function automatic logic [16:0] exp_ctrl(logic [3:0] st, logic mr);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rd, sa, ill;
    logic [1:0] op, pcs, sb2;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rd, sa, ill} = '0;
    op = 2'b00; pcs = 2'b00; sb2 = 2'b00;
    case (st)
      4'd0:  begin mrd = 1; sb2 = 2'b01; pcw = mr; irw = mr; end
      4'd1:  sb2 = 2'b11;
      4'd2:  begin sa = 1; sb2 = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin sa = 1; op = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; op = 2'b01; pcwc = 1; pcs = 2'b01; end
      4'd9:  begin pcw = 1; pcs = 2'b10; end
      4'd10: begin sa = 1; sb2 = 2'b10; end
      4'd11: rw = 1;
      4'd12: ill = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rd, sa, op, pcs, sb2, ill};
  endfunction

  always begin
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      cyc++;
      checks++;
      if (state !== it.st) begin
        fails++;
        $display("[TB] FAIL sb_state cycle %0d: got %0d, expected %0d", cyc, state, it.st);
      end
      checks++;
      if (obs !== it.ctl) begin
        fails++;
        $display("[TB] FAIL sb_ctrl cycle %0d (state %0d): got %b, expected %b", cyc, it.st, obs, it.ctl);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive_cycle(input logic [5:0] op, input logic mr, input logic [3:0] st);
    item_t it;
    @(negedge clk);
    opcode    = op;
    mem_ready = mr;
    it.st  = st;
    it.ctl = exp_ctrl(st, mr);
    sb.push_back(it);
  endtask

  task automatic drive_instr(input logic [5:0] op, input int fstall, input int mstall);
    repeat (fstall) drive_cycle(op, 1'b0, FETCH);
    drive_cycle(op, 1'b1, FETCH);
    drive_cycle(op, 1'b0, DECODE);
    case (op)
      OP_LW: begin
        drive_cycle(op, 1'b0, MEM_ADDR);
        repeat (mstall) drive_cycle(op, 1'b0, MEM_READ);
        drive_cycle(op, 1'b1, MEM_READ);
        drive_cycle(op, 1'b0, MEM_WB);
      end
      OP_SW: begin
        drive_cycle(op, 1'b0, MEM_ADDR);
        repeat (mstall) drive_cycle(op, 1'b0, MEM_WRITE);
        drive_cycle(op, 1'b1, MEM_WRITE);
      end
      OP_RTYPE: begin
        drive_cycle(op, 1'b0, R_EXEC);
        drive_cycle(op, 1'b0, R_WB);
      end
      OP_BEQ:  drive_cycle(op, 1'b0, BRANCH);
      OP_J:    drive_cycle(op, 1'b0, JUMP);
      OP_ADDI: begin
        drive_cycle(op, 1'b0, ADDI_EXEC);
        drive_cycle(op, 1'b0, ADDI_WB);
      end
      default: ;
    endcase
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    opcode    = OP_RTYPE;
    mem_ready = 1'b1;
    #12;
    checks++;
    if (state !== 4'(FETCH)) begin
      fails++;
      $display("[TB] FAIL reset_state: got %0d, expected %0d", state, FETCH);
    end
    checks++;
    if ({PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, illegal} !== 7'b0) begin
      fails++;
      $display("[TB] FAIL reset_strobes: got %b, expected 0000000",
               {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, illegal});
    end
    release_reset();
  endtask

  task automatic test_rtype();
    drive_instr(OP_RTYPE, 0, 0);
  endtask

  task automatic test_lw_stall();
    drive_instr(OP_LW, 0, 3);
  endtask

  task automatic test_beq();
    drive_instr(OP_BEQ, 0, 0);
  endtask

  task automatic test_fetch_stall();
    drive_instr(OP_J, 5, 0);
  endtask

  task automatic test_sw_addi_j();
    drive_instr(OP_SW, 0, 0);
    drive_instr(OP_ADDI, 0, 0);
    drive_instr(OP_J, 0, 0);
    drive_instr(OP_SW, 1, 2);
  endtask

  task automatic test_illegal();
    drive_cycle(6'b111111, 1'b1, FETCH);
    drive_cycle(6'b111111, 1'b0, DECODE);
    repeat (20) drive_cycle(6'b111111, 1'b0, TRAP);
    @(negedge clk);
    #2;
    checks++;
    if (state0 !== 4'(FETCH) || illegal0 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL nop_illegal: got state %0d illegal %b, expected state %0d illegal 0",
               state0, illegal0, FETCH);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'(FETCH) || illegal !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_in_trap: got state %0d illegal %b, expected state %0d illegal 0",
               state, illegal, FETCH);
    end
    release_reset();
  endtask

  task automatic test_reset_mid_write();
    drive_cycle(OP_SW, 1'b1, FETCH);
    drive_cycle(OP_SW, 1'b0, DECODE);
    drive_cycle(OP_SW, 1'b0, MEM_ADDR);
    drive_cycle(OP_SW, 1'b0, MEM_WRITE);
    drive_cycle(OP_SW, 1'b0, MEM_WRITE);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (MemWrite !== 1'b0 || state !== 4'(FETCH) || illegal !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_mid_write: got MemWrite %b state %0d illegal %b, expected 0 %0d 0",
               MemWrite, state, illegal, FETCH);
    end
    release_reset();
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [6];
    ops[0] = OP_RTYPE; ops[1] = OP_LW; ops[2] = OP_SW;
    ops[3] = OP_BEQ;   ops[4] = OP_ADDI; ops[5] = OP_J;
    for (int i = 0; i < 14; i++) begin
      drive_instr(ops[$urandom_range(0, 5)], int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
    drive_cycle(OP_RTYPE, 1'b0, FETCH);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_beq();
    test_fetch_stall();
    test_sw_addi_j();
    test_illegal();
    test_reset_mid_write();
    test_back_to_back();
    @(negedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL sb_drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 Parameter TRAP_ON_ILLEGAL, default 1, meaning: 1 = an unknown opcode enters TRAP; 0 = it is treated as a NOP and the FSM returns to FETCH.
REQ-002 clk  input  1  system clock; all state changes occur on the rising edge.
REQ-003 rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-004 opcode  input  6  instruction-register opcode field; sampled in DECODE.
REQ-005 mem_ready  input  1  memory completion handshake, valid in FETCH, MEM_READ and MEM_WRITE.
REQ-006 ALUopt  output  2  to ALU control: 00 = add, 01 = subtract, 10 = use funct.
REQ-007 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  output  1 each  datapath controls.
REQ-008 PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-009 ALUSrcB  output  2  00 = regB, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
REQ-010 illegal  output  1  sticky illegal-opcode flag.
REQ-011 state  output  4  current state encoding, for debug.

Function
REQ-012 States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB, TRAP.
REQ-013 Opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010; every other opcode is illegal.
REQ-014 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUopt=00, PCSource=00; PCWrite and IRWrite equal mem_ready; the FSM stays in FETCH until mem_ready=1, then goes to DECODE.
REQ-015 DECODE: ALUSrcA=0, ALUSrcB=11, ALUopt=00; the next state depends on opcode:
- LW or SW goes to MEM_ADDR.
- R-type goes to R_EXEC.
- BEQ goes to BRANCH.
- J goes to JUMP.
- ADDI goes to ADDI_EXEC.
- An illegal opcode goes to TRAP if TRAP_ON_ILLEGAL=1, otherwise to FETCH.
REQ-016 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUopt=00; goes to MEM_READ for LW or MEM_WRITE for SW, using the opcode held in the IR.
REQ-017 MEM_READ: MemRead=1, IorD=1; the FSM waits for mem_ready, then goes to MEM_WB.
REQ-018 MEM_WRITE: MemWrite=1, IorD=1; the FSM waits for mem_ready, then goes to FETCH.
REQ-019 MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; goes to FETCH.
REQ-020 R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUopt=10; goes to R_WB.
REQ-021 R_WB: RegWrite=1, RegDst=1, MemtoReg=0; goes to FETCH.
REQ-022 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUopt=01, PCWriteCond=1, PCSource=01; goes to FETCH.
REQ-023 JUMP: PCWrite=1, PCSource=10; goes to FETCH.
REQ-024 ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUopt=00; goes to ADDI_WB.
REQ-025 ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0; goes to FETCH.
REQ-026 TRAP: all strobes are 0 and illegal=1; the FSM stays in TRAP until reset.
REQ-027 Any control not listed for a state is 0.
REQ-028 Outputs are a combinational decode of the registered state, except the mem_ready-qualified PCWrite and IRWrite in FETCH.
REQ-029 If mem_ready is already 1 on the first cycle of FETCH, MEM_READ or MEM_WRITE, the state is left after exactly one cycle.
REQ-030 The minimum cycles per instruction are: J 3, BEQ 3, R-type 4, ADDI 4, SW 4, LW 5.
REQ-031 No state encoding other than the 13 listed is reachable; an unused encoding returns to FETCH on the next edge.

Reset
REQ-032 While rst_n=0, the state is FETCH, illegal=0, and all strobes (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) are forced to 0.
REQ-033 Asserting reset in any state, including mid-wait in MEM_READ, MEM_WRITE or TRAP, aborts the operation immediately and clears illegal.
REQ-034 After rst_n rises, the first clock edge evaluates the FETCH transition.

Structure
REQ-035 The shared package main_ctrl_pkg holds the 4-bit state encodings, the opcode constants, the ALUopt constants (ADD=00, SUB=01, FUNCT=10) and the PCSource and ALUSrcB constants.
REQ-036 One sub-module, main_ctrl_decode, maps state to the control outputs combinationally; the top level holds the state register and the next-state logic.

Verification
REQ-037 R-type: opcode=000000, mem_ready=1 -> state sequence FETCH, DECODE, R_EXEC, R_WB, FETCH; ALUopt=10 in R_EXEC; RegWrite=1 and RegDst=1 in R_WB.
REQ-038 LW with a stall: opcode=100011, mem_ready=0 for 3 cycles in MEM_READ -> MemRead=1 and IorD=1 held for 4 cycles; RegWrite=1 and MemtoReg=1 in MEM_WB; 8 cycles in total.
REQ-039 BEQ: opcode=000100 -> ALUopt=01, PCWriteCond=1, PCSource=01 for one cycle in BRANCH; back in FETCH 3 cycles after the instruction started.
REQ-040 Illegal opcode: opcode=111111 with TRAP_ON_ILLEGAL=1 -> TRAP with illegal=1 for 20 cycles; with TRAP_ON_ILLEGAL=0 -> FETCH with illegal=0.
REQ-041 Reset mid-MEM_WRITE: rst_n=0 while in MEM_WRITE with mem_ready=0 -> MemWrite=0 immediately with no clock edge; state=FETCH and illegal=0.
REQ-042 Fetch stall: mem_ready=0 for 5 cycles in FETCH -> PCWrite=0 and IRWrite=0 throughout; both are 1 only in the cycle where mem_ready=1.
